// File: rtl/spi_fsm.sv
// spi_fsm: SPI memory transaction sequencer (address+R/W byte, then data byte); SPI_FSM_TIMEOUT_EN adds an sclk inactivity abort
module spi_fsm #(
  parameter int CNT_W          = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             sclk_pos,
  input  logic             sclk_neg,
  input  logic [7:0]       sr_pout,
  output logic             addr_we,
  output logic             dm_we,
  output logic             sr_we,
  output logic             miso_bufe,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] bit_count
`ifdef SPI_FSM_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_GET   = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } state_t;
  state_t cur, nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic rw, byte_edge, to_hit;
  logic unused_sr;
  assign unused_sr = ^sr_pout[7:1];
  assign state = cur;
  // the data byte is clocked by the falling edge for reads and the rising edge for writes
  assign byte_edge = rw ? sclk_neg : sclk_pos;
`ifdef SPI_FSM_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;
  // clk cycles since the last sclk edge while a transaction is in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (cur == IDLE || cur == DONE || sclk_pos || sclk_neg) ? '0 : idle_cnt + 1'b1;
  assign to_hit = !cs && cur != IDLE && cur != DONE && !sclk_pos && !sclk_neg
                  && idle_cnt == IW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_to;
  assign unused_to = TIMEOUT_CYCLES[0];
  assign to_hit = 1'b0;
`endif
  // next-state and bit counter; cs high aborts ahead of any edge, the timeout ahead of pending enables
  always_comb begin
    nxt = cur;
    cnt_nxt = bit_count;
    if (cur != IDLE && cs) begin
      nxt = IDLE;
      cnt_nxt = '0;
    end else begin
      case (cur)
        IDLE: if (!cs) begin
          nxt = GET_ADDR;
          cnt_nxt = '0;
        end
        GET_ADDR: if (sclk_pos) begin
          cnt_nxt = bit_count + 1'b1;
          nxt = &bit_count ? GOT_ADDR : GET_ADDR;
        end
        GOT_ADDR: nxt = sr_pout[0] ? READ_LOAD : WRITE_GET;
        READ_LOAD: nxt = READ_SHIFT;
        READ_SHIFT, WRITE_GET: if (byte_edge) begin
          cnt_nxt = bit_count + 1'b1;
          nxt = !(&bit_count) ? cur : cur == READ_SHIFT ? DONE : WRITE_STORE;
        end
        WRITE_STORE: nxt = DONE;
        default: nxt = cur;
      endcase
      if (to_hit) begin
        nxt = DONE;
        cnt_nxt = '0;
      end
    end
  end
  // state, counter, rw latch and enables decoded from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= IDLE;
      bit_count <= '0;
      rw <= 1'b0;
      addr_we <= 1'b0;
      dm_we <= 1'b0;
      sr_we <= 1'b0;
      miso_bufe <= 1'b0;
`ifdef SPI_FSM_TIMEOUT_EN
      timeout <= 1'b0;
`endif
    end else begin
      cur <= nxt;
      bit_count <= cnt_nxt;
      rw <= (cur == GOT_ADDR) ? sr_pout[0] : rw;
      addr_we <= nxt == GOT_ADDR;
      dm_we <= nxt == WRITE_STORE;
      sr_we <= nxt == READ_LOAD;
      miso_bufe <= nxt == READ_SHIFT;
`ifdef SPI_FSM_TIMEOUT_EN
      timeout <= to_hit;
`endif
    end
endmodule

// File: doc/spi_fsm.md
Name: spi_fsm

Overview:
- Transaction controller directly downstream of the conditioned-input plus shift-register stage of the SPI memory datapath.
- Consumes the conditioned chip-select, the SCLK edge pulses and the shift register's parallel output.
- Sequences one SPI memory transaction: 7-bit address + R/W bit, then a data byte.
- Drives the enables: address latch, data-memory write, shift-register parallel load, MISO tristate buffer.

Parameters:
- CNT_W, 3, bit-counter width; one byte = 2^CNT_W sclk edges.
- TIMEOUT_CYCLES, 1024, clk cycles without an sclk edge before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  conditioned chip select, active low.
- sclk_pos  input  1  one-clk pulse on conditioned SCLK rising edge.
- sclk_neg  input  1  one-clk pulse on conditioned SCLK falling edge.
- sr_pout  input  8  shift register parallel output.
- addr_we  output  1  address latch write enable.
- dm_we  output  1  data memory write enable.
- sr_we  output  1  shift register parallel-load enable.
- miso_bufe  output  1  MISO tristate buffer enable.
- state  output  3  current state encoding (debug).
- bit_count  output  CNT_W  current bit counter (debug).

Behaviour:
- Reset values: state=IDLE; bit_count=0; rw latch=0; all enables 0.
- Reset applies asynchronously and may occur mid-transaction; the transaction is abandoned.
- Outputs are Moore (decoded from registered state), so each output follows its state with zero extra latency.
- State encoding:
  - IDLE=0, GET_ADDR=1, GOT_ADDR=2, READ_LOAD=3, READ_SHIFT=4, WRITE_GET=5, WRITE_STORE=6, DONE=7.
- Transitions:
  - IDLE: cs==0 -> GET_ADDR, bit_count=0.
  - GET_ADDR: each sclk_pos increments bit_count; sclk_pos with bit_count==7 -> GOT_ADDR, bit_count wraps to 0.
  - GOT_ADDR (1 clk): addr_we=1; rw latch <= sr_pout[0]; rw=1 -> READ_LOAD, rw=0 -> WRITE_GET.
  - READ_LOAD (1 clk): sr_we=1 -> READ_SHIFT.
  - READ_SHIFT: miso_bufe=1; count sclk_neg; 8th sclk_neg -> DONE.
  - WRITE_GET: count sclk_pos; 8th sclk_pos -> WRITE_STORE.
  - WRITE_STORE (1 clk): dm_we=1 -> DONE.
  - DONE: all enables 0; cs==1 -> IDLE.
- Abort rule: cs==1 in any non-IDLE state -> IDLE next clk, bit_count=0, enables deasserted. cs has priority over sclk edges in the same cycle.
- Edge filtering:
  - sclk_pos is ignored in READ_SHIFT.
  - sclk_neg is ignored in GET_ADDR and WRITE_GET.
  - Edge pulses in the single-cycle states GOT_ADDR, READ_LOAD and WRITE_STORE are ignored and not counted.
- At most one enable is high in any cycle.
- bit_count holds its value when no relevant edge occurs.
- Extra sclk edges after DONE have no effect until cs rises.

Optional Feature:
- Macro: SPI_FSM_TIMEOUT_EN.
- With it defined:
  - An idle counter clears on any sclk_pos/sclk_neg or in IDLE/DONE, and increments in every other state.
  - When it reaches TIMEOUT_CYCLES -> DONE; no pending dm_we or addr_we is issued.
  - Extra output timeout (1 bit) pulses high for that one clk; reset value 0.
- Without it: no counter and no timeout port; the FSM waits indefinitely.

Test Plan:
- Reset: rst_n=0 mid-GET_ADDR (bit_count=3) -> state=0, bit_count=0 and all enables 0 immediately, without waiting for a clk edge.
- Write: cs=0, 8 sclk_pos with final sr_pout=8'h54 (rw=0), then 8 sclk_pos -> addr_we high exactly 1 clk; dm_we high exactly 1 clk after the 16th edge; state=7 until cs=1, then 0.
- Read: address byte 8'hA5 (rw=1) -> addr_we 1 clk, then sr_we 1 clk the next cycle; miso_bufe high until the 8th sclk_neg, low the following clk; dm_we never asserted.
- Abort: cs=1 after 5 address sclk_pos -> next clk state=0, bit_count=0, no addr_we ever.
- Simultaneous: cs rises in the same clk as the 8th address sclk_pos -> state=IDLE, addr_we never asserted.
- With SPI_FSM_TIMEOUT_EN and TIMEOUT_CYCLES=16: stop sclk after 3 edges in WRITE_GET -> timeout pulses at cycle 16, state=7, dm_we never asserted.
